// File: rtl/comp_branch_ctrl_if.sv
// comp_branch_ctrl_if
//   Branch request/response bundle between the issue stage / PC logic and
//   comp_branch_ctrl.
//   Request side : i_br_valid, o_br_ready, i_br_sel, i_br_inv, i_br_tag, i_flush
//   Response side: o_res_valid, i_res_ready, o_res_taken, o_res_err, o_res_tag
//   master = issue/PC side, slave = comp_branch_ctrl.
interface comp_branch_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             i_br_valid;
  logic             o_br_ready;
  logic [3:0]       i_br_sel;
  logic             i_br_inv;
  logic [TAG_W-1:0] i_br_tag;
  logic             i_flush;
  logic             o_res_valid;
  logic             i_res_ready;
  logic             o_res_taken;
  logic             o_res_err;
  logic [TAG_W-1:0] o_res_tag;

  modport master (
    output i_br_valid, i_br_sel, i_br_inv, i_br_tag, i_flush, i_res_ready,
    input  o_br_ready, o_res_valid, o_res_taken, o_res_err, o_res_tag
  );

  modport slave (
    input  i_br_valid, i_br_sel, i_br_inv, i_br_tag, i_flush, i_res_ready,
    output o_br_ready, o_res_valid, o_res_taken, o_res_err, o_res_tag
  );
endinterface

// File: rtl/comp_branch_ctrl.sv
// comp_branch_ctrl
//   Resolves branch conditions against the 12-bit compare register. Tracks
//   outstanding CMPs, holds each branch until every CMP older than it has
//   written back, then selects (and optionally inverts) one condition bit and
//   returns taken/not-taken on a valid/ready response channel.
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low reset
//   i_cmp_issue : pulse, CMP dispatched to the ALU
//   i_cmp_wb    : pulse, compare register takes new flags at this edge
//   i_comp_reg  : compare register {ALWAYS, NEVER, 10 ALU flags}
//   o_cmp_full  : outstanding CMP count at MAX_PEND, issue must hold CMPs
//   o_pending   : outstanding CMP count
//   o_seq_err   : sticky, issue while full or write-back while nothing pending
//   br          : branch request / response bundle (slave side)
module comp_branch_ctrl #(
  parameter int MAX_PEND = 3,
  parameter int TAG_W    = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cmp_issue,
  input  logic        i_cmp_wb,
  input  logic [11:0] i_comp_reg,
  output logic        o_cmp_full,
  output logic [1:0]  o_pending,
  output logic        o_seq_err,
  comp_branch_ctrl_if.slave br
);

  localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, RESP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       pending, pending_nxt;
  logic [1:0]       wait_cnt, wait_cnt_nxt;
  logic [3:0]       timer, timer_nxt;
  logic [3:0]       sel_q, sel_nxt;
  logic             inv_q, inv_nxt;
  logic [TAG_W-1:0] tag_q, tag_nxt;
  logic             res_valid, res_valid_nxt;
  logic             res_taken, res_taken_nxt;
  logic             res_err, res_err_nxt;
  logic [TAG_W-1:0] res_tag, res_tag_nxt;
  logic             seq_err;
  logic             issue_ok, wb_ok;

  // Outstanding CMP bookkeeping. A write-back in the same cycle frees a slot,
  // so an issue at full is only rejected when no write-back accompanies it.
  always_comb begin
    issue_ok    = i_cmp_issue && ((pending != PEND_MAX) || i_cmp_wb);
    wb_ok       = i_cmp_wb && (pending != 2'd0);
    pending_nxt = pending + 2'(issue_ok) - 2'(wb_ok);
  end

  // Next-state and response logic. A branch only counts CMPs that are older
  // than it (including one issued in its accept cycle), so wait_cnt is a
  // snapshot of the post-update pending count and later issues never touch it.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    timer_nxt     = timer;
    sel_nxt       = sel_q;
    inv_nxt       = inv_q;
    tag_nxt       = tag_q;
    res_valid_nxt = res_valid;
    res_taken_nxt = res_taken;
    res_err_nxt   = res_err;
    res_tag_nxt   = res_tag;

    case (state)
      IDLE: begin
        if (br.i_br_valid && !br.i_flush) begin
          sel_nxt      = br.i_br_sel;
          inv_nxt      = br.i_br_inv;
          tag_nxt      = br.i_br_tag;
          wait_cnt_nxt = pending_nxt;
          timer_nxt    = 4'd0;
          state_nxt    = (pending_nxt == 2'd0) ? EVAL : WAIT;
        end
      end
      WAIT: begin
        timer_nxt = timer + 4'd1;
        if (i_cmp_wb && (wait_cnt != 2'd0)) begin
          wait_cnt_nxt = wait_cnt - 2'd1;
          if (wait_cnt == 2'd1) begin
            state_nxt = EVAL;
          end
        end
        // Completion in the final cycle wins over the timeout.
        if ((state_nxt != EVAL) && (timer == TMO_LAST)) begin
          state_nxt     = RESP;
          res_valid_nxt = 1'b1;
          res_taken_nxt = 1'b0;
          res_err_nxt   = 1'b1;
          res_tag_nxt   = tag_q;
        end
      end
      EVAL: begin
        state_nxt     = RESP;
        res_valid_nxt = 1'b1;
        res_tag_nxt   = tag_q;
        if (sel_q <= 4'd11) begin
          res_taken_nxt = i_comp_reg[sel_q] ^ inv_q;
          res_err_nxt   = 1'b0;
        end else begin
          res_taken_nxt = 1'b0;
          res_err_nxt   = 1'b1;
        end
      end
      RESP: begin
        if (br.i_res_ready) begin
          state_nxt     = IDLE;
          res_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Flush abandons the in-flight branch; pending is untouched because the
    // flushed CMPs still write back later.
    if (br.i_flush && (state != IDLE)) begin
      state_nxt     = IDLE;
      res_valid_nxt = 1'b0;
      wait_cnt_nxt  = 2'd0;
      timer_nxt     = 4'd0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= 2'd0;
      wait_cnt  <= 2'd0;
      timer     <= 4'd0;
      sel_q     <= 4'd0;
      inv_q     <= 1'b0;
      tag_q     <= '0;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      res_err   <= 1'b0;
      res_tag   <= '0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timer     <= timer_nxt;
      sel_q     <= sel_nxt;
      inv_q     <= inv_nxt;
      tag_q     <= tag_nxt;
      res_valid <= res_valid_nxt;
      res_taken <= res_taken_nxt;
      res_err   <= res_err_nxt;
      res_tag   <= res_tag_nxt;
      seq_err   <= seq_err | (i_cmp_issue && !issue_ok) | (i_cmp_wb && !wb_ok);
    end
  end

  assign o_cmp_full     = (pending == PEND_MAX);
  assign o_pending      = pending;
  assign o_seq_err      = seq_err;
  assign br.o_br_ready  = (state == IDLE);
  assign br.o_res_valid = res_valid;
  assign br.o_res_taken = res_taken;
  assign br.o_res_err   = res_err;
  assign br.o_res_tag   = res_tag;

endmodule
